// File: rtl/zmod_adc_pkg.sv
// Shared constants, FSM encoding and the rounding helper for the ZMOD ADC decimator.
package zmod_adc_pkg;

    localparam int DATA_W          = 14;
    localparam int MAX_LOG2_DEC    = 8;
    localparam int ACC_W           = DATA_W + MAX_LOG2_DEC;
    localparam int CNT_W           = MAX_LOG2_DEC;
    localparam int FIFO_W          = 2 * DATA_W;
    localparam int RAMP_LOCK_COUNT = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Round-half-up average: (sum + 2^(k-1)) >>> k, or the sum itself for k = 0.
    // A full block of 2^k in-range samples always averages back into DATA_W bits.
    function automatic logic signed [DATA_W-1:0] round_shift(
        input logic signed [ACC_W-1:0] sum,
        input logic [3:0]              k
    );
        logic signed [ACC_W-1:0] bias;
        logic signed [ACC_W-1:0] biased;
        bias = '0;
        if (k != 4'd0) begin
            bias = ACC_W'(1) << (k - 4'd1);
        end
        biased = (sum + bias) >>> k;
        return biased[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/zmod_adc_decimator_if.sv
// Sample-in / result-out bus of the decimator.
// Handshake: a sample is taken on every clk edge where i_valid = 1 (no backpressure
// on the input side); a result word moves on every clk edge where o_valid = 1 and
// i_ready = 1, and o14_data_a/b stay stable while o_valid = 1 and i_ready = 0.
interface zmod_adc_decimator_if;
    import zmod_adc_pkg::*;

    logic              i_valid;
    logic [DATA_W-1:0] i14_data_a;
    logic [DATA_W-1:0] i14_data_b;
    logic [DATA_W-1:0] o14_data_a;
    logic [DATA_W-1:0] o14_data_b;
    logic              o_valid;
    logic              i_ready;

    modport master (
        output i_valid, i14_data_a, i14_data_b, i_ready,
        input  o14_data_a, o14_data_b, o_valid
    );

    modport slave (
        input  i_valid, i14_data_a, i14_data_b, i_ready,
        output o14_data_a, o14_data_b, o_valid
    );

endinterface

// File: rtl/zmod_adc_out_fifo.sv
// Two-entry result FIFO; a write while full is accepted only if a read frees a slot
// in the same cycle, otherwise the caller sees the word as dropped.
module zmod_adc_out_fifo
    import zmod_adc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_wr,
    input  logic [FIFO_W-1:0] i28_wr_data,
    output logic [FIFO_W-1:0] o28_rd_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_full
);

    logic [FIFO_W-1:0] r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic              w_rd;
    logic              w_wr;

    assign o_valid     = (r_count != 2'd0);
    assign o_full      = (r_count == 2'd2);
    assign o28_rd_data = r_mem[r_rd_ptr];
    assign w_rd        = o_valid & i_ready;
    assign w_wr        = i_wr & (~o_full | w_rd);

    // Pointer/occupancy bookkeeping and storage; flush empties without touching data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= i28_wr_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_rd) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_wr} - {1'b0, w_rd};
        end
    end

endmodule

// File: rtl/zmod_adc_decimator.sv
// Block-averaging decimator for both ADC channels with a ramp-pattern checker on A.
// Pipeline: block sum register -> rounded result register -> 2-entry output FIFO.
module zmod_adc_decimator
    import zmod_adc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_adc_configured,
    input  logic [3:0]  i4_log2_dec,
    input  logic        i_check_en,
    input  logic        i_clr,
    output logic        o_overflow,
    output logic [15:0] o16_err_count,
    output logic        o_ramp_locked,
    zmod_adc_decimator_if.slave bus
);

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    w_take;
    logic                    w_flush;
    logic                    w_load_k;
    logic [3:0]              w_k_in;
    logic [3:0]              r_k;
    logic [3:0]              r_sum_k;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W:0]          w_blk_max;
    logic                    w_last;
    logic signed [ACC_W-1:0] r_acc_a, r_acc_b;
    logic signed [ACC_W-1:0] w_sum_a, w_sum_b;
    logic signed [ACC_W-1:0] r_sum_a, r_sum_b;
    logic                    r_sum_valid;
    logic                    r_res_valid;
    logic [DATA_W-1:0]       r_res_a, r_res_b;
    logic                    w_fifo_valid;
    logic                    w_fifo_ready;
    logic                    w_fifo_full;
    logic                    w_fifo_rd;
    logic                    w_drop;
    logic [FIFO_W-1:0]       w_fifo_rd_data;
    logic                    r_overflow;
    logic [DATA_W-1:0]       r_prev_a;
    logic [DATA_W-1:0]       w_ramp_exp;
    logic                    r_seeded;
    logic [4:0]              r_good;
    logic [15:0]             r_err_count;

    assign w_k_in    = (i4_log2_dec > 4'(MAX_LOG2_DEC)) ? 4'(MAX_LOG2_DEC) : i4_log2_dec;
    assign w_blk_max = ((CNT_W+1)'(1) << r_k) - (CNT_W+1)'(1);
    assign w_last    = ({1'b0, r_cnt} == w_blk_max);
    assign w_sum_a   = r_acc_a + $signed({{MAX_LOG2_DEC{bus.i14_data_a[DATA_W-1]}}, bus.i14_data_a});
    assign w_sum_b   = r_acc_b + $signed({{MAX_LOG2_DEC{bus.i14_data_b[DATA_W-1]}}, bus.i14_data_b});

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    // FSM next state: RUN exactly while the driver reports configuration done.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (i_adc_configured)  w_next_state = ST_RUN;
            ST_RUN:  if (!i_adc_configured) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM outputs: latch k on entry, take samples in RUN, flush on configuration loss.
    always_comb begin
        w_load_k = 1'b0;
        w_flush  = 1'b0;
        w_take   = 1'b0;
        case (r_state)
            ST_IDLE: w_load_k = i_adc_configured;
            ST_RUN: begin
                w_flush = ~i_adc_configured;
                w_take  = i_adc_configured & bus.i_valid;
            end
            default: ;
        endcase
    end

    // Accumulate a block; on its last sample hand the full sum and its k downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_a     <= '0;
            r_acc_b     <= '0;
            r_cnt       <= '0;
            r_k         <= 4'd0;
            r_sum_a     <= '0;
            r_sum_b     <= '0;
            r_sum_k     <= 4'd0;
            r_sum_valid <= 1'b0;
        end else begin
            r_sum_valid <= 1'b0;
            if (w_load_k) begin
                r_k     <= w_k_in;
                r_acc_a <= '0;
                r_acc_b <= '0;
                r_cnt   <= '0;
            end else if (w_flush) begin
                r_acc_a <= '0;
                r_acc_b <= '0;
                r_cnt   <= '0;
            end else if (w_take) begin
                if (w_last) begin
                    r_sum_a     <= w_sum_a;
                    r_sum_b     <= w_sum_b;
                    r_sum_k     <= r_k;
                    r_sum_valid <= 1'b1;
                    r_acc_a     <= '0;
                    r_acc_b     <= '0;
                    r_cnt       <= '0;
                    r_k         <= w_k_in;
                end else begin
                    r_acc_a <= w_sum_a;
                    r_acc_b <= w_sum_b;
                    r_cnt   <= r_cnt + 1'b1;
                end
            end
        end
    end

    // Result register: rounded average of the captured block.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_a     <= '0;
            r_res_b     <= '0;
        end else begin
            r_res_valid <= r_sum_valid & ~w_flush;
            if (r_sum_valid) begin
                r_res_a <= round_shift(r_sum_a, r_sum_k);
                r_res_b <= round_shift(r_sum_b, r_sum_k);
            end
        end
    end

    // Output is forced idle while the ADC is not configured.
    assign w_fifo_ready   = bus.i_ready & i_adc_configured;
    assign w_fifo_rd      = w_fifo_valid & w_fifo_ready;
    assign w_drop         = r_res_valid & w_fifo_full & ~w_fifo_rd & ~w_flush;
    assign bus.o_valid    = w_fifo_valid & i_adc_configured;
    assign bus.o14_data_a = w_fifo_rd_data[FIFO_W-1:DATA_W];
    assign bus.o14_data_b = w_fifo_rd_data[DATA_W-1:0];

    zmod_adc_out_fifo u_out_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (w_flush),
        .i_wr        (r_res_valid),
        .i28_wr_data ({r_res_a, r_res_b}),
        .o28_rd_data (w_fifo_rd_data),
        .o_valid     (w_fifo_valid),
        .i_ready     (w_fifo_ready),
        .o_full      (w_fifo_full)
    );

    // Sticky overflow flag; clear beats a coincident drop.
    always_ff @(posedge clk) begin
        if (rst)         r_overflow <= 1'b0;
        else if (i_clr)  r_overflow <= 1'b0;
        else if (w_drop) r_overflow <= 1'b1;
    end

    assign w_ramp_exp = r_prev_a + 1'b1;

    // Ramp checker on channel A: first sample after enable seeds, later ones must step by +1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_a    <= '0;
            r_seeded    <= 1'b0;
            r_good      <= 5'd0;
            r_err_count <= 16'd0;
        end else begin
            if (w_take && i_check_en) begin
                r_prev_a <= bus.i14_data_a;
                r_seeded <= 1'b1;
                if (r_seeded) begin
                    if (bus.i14_data_a == w_ramp_exp) begin
                        if (r_good != 5'(RAMP_LOCK_COUNT)) r_good <= r_good + 1'b1;
                    end else begin
                        r_good <= 5'd0;
                        if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 1'b1;
                    end
                end
            end else if (!i_check_en) begin
                r_seeded <= 1'b0;
            end
            if (i_clr) r_err_count <= 16'd0;
        end
    end

    assign o_overflow    = r_overflow;
    assign o16_err_count = r_err_count;
    assign o_ramp_locked = (r_good == 5'(RAMP_LOCK_COUNT));

endmodule

// File: tb/tb_zmod_adc_decimator.sv
// Directed bench for zmod_adc_decimator: pass-through, averaging, overflow,
// ramp checker, configuration loss, ratio change, clamp and mid-block reset.
module tb_zmod_adc_decimator;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg;
    logic [3:0]  log2_dec;
    logic        check_en;
    logic        clr;
    logic        overflow;
    logic [15:0] err_count;
    logic        locked;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    zmod_adc_decimator_if bus ();

    zmod_adc_decimator dut (
        .clk              (clk),
        .rst              (rst),
        .i_adc_configured (cfg),
        .i4_log2_dec      (log2_dec),
        .i_check_en       (check_en),
        .i_clr            (clr),
        .o_overflow       (overflow),
        .o16_err_count    (err_count),
        .o_ramp_locked    (locked),
        .bus              (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int a, input int b);
        bus.i_valid    = 1'b1;
        bus.i14_data_a = 14'(a);
        bus.i14_data_b = 14'(b);
    endtask

    task automatic reconfig(input logic [3:0] k);
        bus.i_valid = 1'b0;
        cfg = 1'b0;
        tick();
        log2_dec = k;
        cfg = 1'b1;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cfg = 1'b0; log2_dec = 4'd0; check_en = 1'b0; clr = 1'b0;
        bus.i_valid = 1'b0; bus.i14_data_a = '0; bus.i14_data_b = '0; bus.i_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_err", err_count, 0);
        chk("rst_lock", locked, 0);
        chk("rst_data_a", $signed(bus.o14_data_a), 0);

        // IDLE ignores samples
        drive(55, 55); tick(); tick(); tick();
        bus.i_valid = 1'b0; tick(); tick();
        chk("idle_ignore", bus.o_valid, 0);

        // k=0 pass-through, two-cycle latency, no bubbles
        cfg = 1'b1; tick();
        drive(100, -5); tick();
        chk("k0_lat_e0", bus.o_valid, 0);
        drive(101, -6); tick();
        chk("k0_lat_e1", bus.o_valid, 0);
        drive(102, -7); tick();
        chk("k0_v0", bus.o_valid, 1);
        chk("k0_a0", $signed(bus.o14_data_a), 100);
        chk("k0_b0", $signed(bus.o14_data_b), -5);
        bus.i_valid = 1'b0; tick();
        chk("k0_v1", bus.o_valid, 1);
        chk("k0_a1", $signed(bus.o14_data_a), 101);
        chk("k0_b1", $signed(bus.o14_data_b), -6);
        tick();
        chk("k0_a2", $signed(bus.o14_data_a), 102);
        chk("k0_b2", $signed(bus.o14_data_b), -7);
        tick();
        chk("k0_drain", bus.o_valid, 0);
        chk("k0_ovf", overflow, 0);

        // k=2 average with round-half-up
        reconfig(4'd2);
        drive(1, -1); tick();
        drive(2, -2); tick();
        drive(3, -2); tick();
        drive(4, -2); tick();
        bus.i_valid = 1'b0; tick();
        chk("k2_lat", bus.o_valid, 0);
        tick();
        chk("k2_v", bus.o_valid, 1);
        chk("k2_a", $signed(bus.o14_data_a), 3);
        chk("k2_b", $signed(bus.o14_data_b), -2);
        tick();
        chk("k2_drain", bus.o_valid, 0);

        // overflow: ready low, third result dropped, first two kept in order
        reconfig(4'd0);
        bus.i_ready = 1'b0;
        drive(11, 21); tick();
        drive(12, 22); tick();
        drive(13, 23); tick();
        bus.i_valid = 1'b0; tick(); tick();
        chk("ovf_set", overflow, 1);
        chk("ovf_v", bus.o_valid, 1);
        chk("ovf_head", $signed(bus.o14_data_a), 11);
        tick();
        chk("ovf_hold", $signed(bus.o14_data_a), 11);
        chk("ovf_hold_b", $signed(bus.o14_data_b), 21);
        bus.i_ready = 1'b1; tick();
        chk("ovf_second", $signed(bus.o14_data_a), 12);
        tick();
        chk("ovf_empty", bus.o_valid, 0);
        chk("ovf_sticky", overflow, 1);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("ovf_clr", overflow, 0);

        // ramp checker across the 8191 -> -8192 wrap
        check_en = 1'b1;
        for (int i = 0; i < 25; i++) begin
            drive(8180 + i, 0); tick();
            if (i == 15) chk("ramp_lock15", locked, 0);
            if (i == 16) chk("ramp_lock16", locked, 1);
        end
        chk("ramp_locked", locked, 1);
        chk("ramp_err0", err_count, 0);
        drive(-8177, 0); tick();
        chk("ramp_skip_err", err_count, 1);
        chk("ramp_skip_lock", locked, 0);
        for (int i = 1; i <= 16; i++) begin
            drive(-8177 + i, 0); tick();
            if (i == 15) chk("ramp_relock15", locked, 0);
        end
        chk("ramp_relock", locked, 1);
        chk("ramp_err1", err_count, 1);
        clr = 1'b1; drive(-8150, 0); tick(); clr = 1'b0;
        chk("ramp_clr_wins", err_count, 0);
        chk("ramp_clr_lock", locked, 0);
        drive(-8100, 0); tick();
        chk("ramp_err_again", err_count, 1);
        check_en = 1'b0; bus.i_valid = 1'b0; tick();

        // configuration loss mid-block discards the partial block
        reconfig(4'd2);
        drive(40, 40); tick();
        drive(41, 41); tick();
        bus.i_valid = 1'b0; cfg = 1'b0; tick(); tick();
        chk("cfg_drop_v", bus.o_valid, 0);
        tick();
        chk("cfg_drop_v2", bus.o_valid, 0);
        cfg = 1'b1; tick();
        drive(4, -4); tick();
        drive(5, -5); tick();
        drive(6, -6); tick();
        drive(8, -8); tick();
        bus.i_valid = 1'b0; tick();
        chk("cfg_re_lat", bus.o_valid, 0);
        tick();
        chk("cfg_re_v", bus.o_valid, 1);
        chk("cfg_re_a", $signed(bus.o14_data_a), 6);
        chk("cfg_re_b", $signed(bus.o14_data_b), -6);
        tick();
        chk("cfg_re_drain", bus.o_valid, 0);

        // ratio change mid-block applies at the next boundary
        drive(10, 1); tick();
        log2_dec = 4'd1;
        drive(20, 1); tick();
        drive(30, 1); tick();
        drive(41, 2); tick();
        drive(7, -3); tick();
        drive(8, -4); tick();
        chk("kchg_v1", bus.o_valid, 1);
        chk("kchg_a1", $signed(bus.o14_data_a), 25);
        chk("kchg_b1", $signed(bus.o14_data_b), 1);
        bus.i_valid = 1'b0; tick();
        chk("kchg_gap", bus.o_valid, 0);
        tick();
        chk("kchg_v2", bus.o_valid, 1);
        chk("kchg_a2", $signed(bus.o14_data_a), 8);
        chk("kchg_b2", $signed(bus.o14_data_b), -3);
        tick();

        // exponent above 8 clamps to 8 (256-sample blocks)
        reconfig(4'd15);
        for (int i = 0; i < 256; i++) begin
            drive((i == 255) ? 133 : 5, -3); tick();
        end
        bus.i_valid = 1'b0; tick();
        chk("clamp_lat", bus.o_valid, 0);
        tick();
        chk("clamp_v", bus.o_valid, 1);
        chk("clamp_a", $signed(bus.o14_data_a), 6);
        chk("clamp_b", $signed(bus.o14_data_b), -3);
        tick();

        // reset mid-block with a word pending
        reconfig(4'd1);
        bus.i_ready = 1'b0;
        drive(1, 2); tick();
        drive(2, 2); tick();
        bus.i_valid = 1'b0; tick(); tick();
        chk("rstm_pending", bus.o_valid, 1);
        drive(9, 9); rst = 1'b1; tick();
        rst = 1'b0; bus.i_valid = 1'b0; bus.i_ready = 1'b1;
        chk("rstm_valid", bus.o_valid, 0);
        chk("rstm_data", $signed(bus.o14_data_a), 0);
        tick();
        drive(3, -1); tick();
        drive(5, -2); tick();
        bus.i_valid = 1'b0; tick(); tick();
        chk("rstm_after_v", bus.o_valid, 1);
        chk("rstm_after_a", $signed(bus.o14_data_a), 4);
        chk("rstm_after_b", $signed(bus.o14_data_b), -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
